// File: rtl/mul_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sched_pkg
//  Description : Shared types and constants for the multiplier scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_sched_pkg;

    localparam int WIDTH_DEF       = 8;
    localparam int MUL_LATENCY_DEF = 10;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/mul_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sched_if
//  Description : Request/response channels and multiplier hookup of mul_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_sched_if #(
    parameter int WIDTH = 8
) ();
    logic                 req0_valid;
    logic                 req1_valid;
    logic                 req0_ready;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic                 resp0_valid;
    logic                 resp1_valid;
    logic                 resp0_ready;
    logic                 resp1_ready;
    logic [2*WIDTH-1:0]   resp_data;
    logic                 mul_rst;
    logic [WIDTH-1:0]     mul_in1;
    logic [WIDTH-1:0]     mul_in2;
    logic [2*WIDTH-1:0]   mul_out;

    // Scheduler side
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  resp0_ready, resp1_ready, mul_out,
        output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
        output mul_rst, mul_in1, mul_in2
    );

    // Requesters plus multiplier side
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output resp0_ready, resp1_ready, mul_out,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
        input  mul_rst, mul_in1, mul_in2
    );
endinterface
`default_nettype wire

// File: rtl/mul_sched_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin arbiter holding the last-granted pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       update_i,
    input  logic       gnt_id_i,
    output logic [1:0] grant_o
);

    // Reset to "last granted = 1" so requester 0 wins the first contention.
    logic last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (update_i) begin
            last_q <= gnt_id_i;
        end
    end

    always_comb begin
        grant_o = 2'b00;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mul_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sched
//  Description : Round-robin scheduler framing jobs onto a shared shift-add
//                multiplier by pulsing its reset and capturing the product.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    mul_sched_if.slave  bus
);

    sched_state_t         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     in1_q, in1_d;
    logic [WIDTH-1:0]     in2_q, in2_d;
    logic [2*WIDTH-1:0]   data_q, data_d;
    logic                 tag_q, tag_d;

    logic [1:0]           grant;
    logic                 accept;
    logic                 resp_hs;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({bus.req1_valid, bus.req0_valid}),
        .update_i (resp_hs),
        .gnt_id_i (tag_q),
        .grant_o  (grant)
    );

    assign accept  = (state_q == IDLE) && !rst && (grant != 2'b00);
    assign resp_hs = (state_q == DONE) && (tag_q ? bus.resp1_ready : bus.resp0_ready);

    // Handshake outputs are masked during reset even if the state is already IDLE.
    assign bus.req0_ready  = (state_q == IDLE) && !rst && grant[0];
    assign bus.req1_ready  = (state_q == IDLE) && !rst && grant[1];
    assign bus.resp0_valid = (state_q == DONE) && !rst && !tag_q;
    assign bus.resp1_valid = (state_q == DONE) && !rst && tag_q;
    assign bus.resp_data   = data_q;
    assign bus.mul_rst     = rst || (state_q == ARM);
    assign bus.mul_in1     = in1_q;
    assign bus.mul_in2     = in2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        data_d  = data_q;
        tag_d   = tag_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tag_d   = grant[1];
                    in1_d   = grant[1] ? bus.req1_a : bus.req0_a;
                    in2_d   = grant[1] ? bus.req1_b : bus.req0_b;
                    state_d = ARM;
                end
            end
            ARM: begin
                cnt_d   = CNT_W'(1);
                state_d = BUSY;
            end
            BUSY: begin
                // The counter tracks the multiplier frame position since its reset pulse.
                if (cnt_q == CNT_W'(MUL_LATENCY)) begin
                    data_d  = bus.mul_out;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (resp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            data_q  <= '0;
            tag_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_sched
//  Description : Self-checking bench for mul_sched with a shift-add multiplier model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mul_sched_if #(.WIDTH(8)) bus ();

    mul_sched #(.WIDTH(8), .MUL_LATENCY(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Free-running 10-step shift-add multiplier: product visible only in frame step 9.
    logic [3:0]  m_cnt = 4'd0;
    logic [15:0] m_acc = 16'd0;
    logic [15:0] m_out = 16'd0;
    always @(posedge clk) begin
        if (bus.mul_rst) begin
            m_cnt <= 4'd0;
            m_acc <= 16'd0;
            m_out <= 16'hDEAD;
        end else begin
            m_cnt <= (m_cnt == 4'd9) ? 4'd0 : m_cnt + 4'd1;
            if (m_cnt < 4'd8 && bus.mul_in2[m_cnt[2:0]])
                m_acc <= m_acc + ({8'd0, bus.mul_in1} << m_cnt);
            if (m_cnt == 4'd8) m_out <= m_acc;
            if (m_cnt == 4'd9) begin
                m_out <= 16'hDEAD;
                m_acc <= 16'd0;
            end
        end
    end
    assign bus.mul_out = m_out;

    // Event logs, each entry is the cycle index of the event.
    int          mr_q[$];
    int          acc_who[$];
    int          acc_cyc[$];
    int          hs_who[$];
    int          hs_cyc[$];
    logic [15:0] hs_data[$];
    int          rv0_q[$];
    int          rv1_q[$];
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.mul_rst) mr_q.push_back(cyc);
            if (bus.req0_valid && bus.req0_ready) begin acc_who.push_back(0); acc_cyc.push_back(cyc); end
            if (bus.req1_valid && bus.req1_ready) begin acc_who.push_back(1); acc_cyc.push_back(cyc); end
            if (bus.resp0_valid) rv0_q.push_back(cyc);
            if (bus.resp1_valid) rv1_q.push_back(cyc);
            if (bus.resp0_valid && bus.resp0_ready) begin
                hs_who.push_back(0); hs_cyc.push_back(cyc); hs_data.push_back(bus.resp_data);
            end
            if (bus.resp1_valid && bus.resp1_ready) begin
                hs_who.push_back(1); hs_cyc.push_back(cyc); hs_data.push_back(bus.resp_data);
            end
        end
    end

    task automatic set_req(input int who, input bit v, input logic [7:0] a, input logic [7:0] b);
        if (who == 0) begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic idle_inputs();
        set_req(0, 1'b0, 8'd0, 8'd0);
        set_req(1, 1'b0, 8'd0, 8'd0);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
    endtask

    task automatic clear_logs();
        mr_q.delete(); acc_who.delete(); acc_cyc.delete();
        hs_who.delete(); hs_cyc.delete(); hs_data.delete();
        rv0_q.delete(); rv1_q.delete();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    // Drives one job from a single requester and reports what the logs saw.
    task automatic run_job(input int who, input logic [7:0] a, input logic [7:0] b,
                           output bit ok, output logic [15:0] data, output int lat);
        int base_a = acc_cyc.size();
        int base_h = hs_cyc.size();
        ok = 1'b0; data = 16'd0; lat = -1;
        set_req(who, 1'b1, a, b);
        if (who == 0) bus.resp0_ready = 1'b1; else bus.resp1_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_cyc.size() > base_a) break;
        end
        set_req(who, 1'b0, 8'd0, 8'd0);
        for (int i = 0; i < 30; i++) begin
            if (hs_cyc.size() > base_h) break;
            @(negedge clk);
        end
        if (acc_cyc.size() > base_a && hs_cyc.size() > base_h) begin
            ok   = (acc_who[base_a] == who) && (hs_who[base_h] == who);
            data = hs_data[base_h];
            lat  = hs_cyc[base_h] - acc_cyc[base_a];
        end
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        set_req(0, 1'b1, 8'd5, 8'd6);
        set_req(1, 1'b1, 8'd7, 8'd8);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready: got %b want 0", bus.req0_ready); end
        n_tests++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req1_ready: got %b want 0", bus.req1_ready); end
        n_tests++; if (bus.resp0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp0_valid: got %b want 0", bus.resp0_valid); end
        n_tests++; if (bus.resp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp1_valid: got %b want 0", bus.resp1_valid); end
        n_tests++; if (bus.mul_rst !== 1'b1) begin n_fail++; $display("FAIL reset_mul_rst: got %b want 1", bus.mul_rst); end
        n_tests++; if (bus.mul_in1 !== 8'd0 || bus.mul_in2 !== 8'd0) begin n_fail++; $display("FAIL reset_mul_in: got %0d,%0d want 0,0", bus.mul_in1, bus.mul_in2); end
        n_tests++; if (bus.resp_data !== 16'd0) begin n_fail++; $display("FAIL reset_resp_data: got %0d want 0", bus.resp_data); end
        idle_inputs();
        rst = 1'b0;
        clear_logs();
        @(negedge clk); #1;
        n_tests++; if (bus.mul_rst !== 1'b0) begin n_fail++; $display("FAIL idle_mul_rst: got %b want 0", bus.mul_rst); end
    endtask

    task automatic test_single();
        bit ok; logic [15:0] d; int lat;
        do_reset();
        run_job(0, 8'd13, 8'd11, ok, d, lat);
        n_tests++; if (!ok || lat != 12) begin n_fail++; $display("FAIL single_latency: got ok=%0d lat=%0d want ok=1 lat=12", ok, lat); end
        n_tests++; if (d !== 16'd143) begin n_fail++; $display("FAIL single_data: got %0d want 143", d); end
        n_tests++; if (mr_q.size() != 1 || acc_cyc.size() < 1 || mr_q[0] != acc_cyc[0] + 1) begin
            n_fail++; $display("FAIL single_mul_rst: got %0d pulses first at %0d want 1 pulse at accept+1", mr_q.size(), (mr_q.size() > 0) ? mr_q[0] : -1);
        end
        n_tests++; if (rv0_q.size() < 1 || acc_cyc.size() < 1 || rv0_q[0] != acc_cyc[0] + 12) begin
            n_fail++; $display("FAIL single_resp_cycle: got %0d want accept+12", (rv0_q.size() > 0) ? rv0_q[0] : -1);
        end
        n_tests++; if (rv1_q.size() != 0) begin n_fail++; $display("FAIL single_resp1_quiet: got %0d valid cycles want 0", rv1_q.size()); end
    endtask

    task automatic test_extremes();
        logic [7:0] ta[3];
        logic [7:0] tb[3];
        bit ok; logic [15:0] d; int lat;
        logic [7:0] a, b;
        int exp;
        ta[0] = 8'd255; tb[0] = 8'd255;
        ta[1] = 8'd0;   tb[1] = 8'd200;
        ta[2] = 8'd1;   tb[2] = 8'd255;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i < 3) begin
                a = ta[i]; b = tb[i];
            end else begin
                a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
            end
            exp = int'(a) * int'(b);
            run_job(i % 2, a, b, ok, d, lat);
            n_tests++; if (!ok || lat != 12 || d !== 16'(exp)) begin
                n_fail++; $display("FAIL product_%0dx%0d: got %0d lat=%0d ok=%0d want %0d lat=12", a, b, d, lat, ok, exp);
            end
        end
    endtask

    task automatic test_contention();
        int exp_who[3];
        int exp_dat[3];
        exp_who[0] = 0; exp_who[1] = 1; exp_who[2] = 0;
        exp_dat[0] = 15; exp_dat[1] = 63; exp_dat[2] = 15;
        do_reset();
        set_req(0, 1'b1, 8'd3, 8'd5);
        set_req(1, 1'b1, 8'd7, 8'd9);
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (hs_cyc.size() >= 3) break;
            @(negedge clk);
        end
        n_tests++; if (hs_cyc.size() < 3) begin n_fail++; $display("FAIL contention_timeout: got %0d responses want 3", hs_cyc.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                n_tests++; if (hs_who[k] != exp_who[k] || acc_who[k] != exp_who[k] || hs_data[k] !== 16'(exp_dat[k])) begin
                    n_fail++; $display("FAIL contention_job%0d: got resp%0d grant%0d data %0d want resp%0d data %0d",
                                       k, hs_who[k], acc_who[k], hs_data[k], exp_who[k], exp_dat[k]);
                end
            end
            n_tests++; if (acc_cyc[1] - acc_cyc[0] != 13 || acc_cyc[2] - acc_cyc[1] != 13) begin
                n_fail++; $display("FAIL contention_spacing: got %0d,%0d want 13,13", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] a, b;
        logic [15:0] exp;
        int bad = 0;
        a = 8'($urandom_range(1, 255)); b = 8'($urandom_range(1, 255));
        exp = 16'(int'(a) * int'(b));
        do_reset();
        set_req(1, 1'b1, a, b);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (acc_cyc.size() > 0) set_req(1, 1'b0, 8'd0, 8'd0);
            if (bus.resp1_valid) break;
        end
        n_tests++; if (bus.resp1_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resp_timeout: got resp1_valid=%b want 1", bus.resp1_valid); end
        set_req(0, 1'b1, 8'd2, 8'd3);
        #1;
        for (int k = 0; k < 20; k++) begin
            if (bus.resp_data !== exp || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.resp1_valid !== 1'b1) bad++;
            @(negedge clk); #1;
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles want 0 (data %0d want %0d)", bad, bus.resp_data, exp); end
        bus.resp1_ready = 1'b1;
        @(negedge clk);
        bus.resp1_ready = 1'b0;
        #1;
        n_tests++; if (bus.req0_ready !== 1'b1 || bus.resp1_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got req0_ready=%b resp1_valid=%b want 1,0", bus.req0_ready, bus.resp1_valid);
        end
        n_tests++; if (hs_data.size() != 1 || hs_data[0] !== exp) begin
            n_fail++; $display("FAIL bp_data: got %0d handshakes data %0d want 1 with %0d", hs_data.size(), (hs_data.size() > 0) ? hs_data[0] : 16'd0, exp);
        end
        set_req(0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic test_reset_mid();
        bit ok; logic [15:0] d; int lat;
        int acc;
        do_reset();
        set_req(0, 1'b1, 8'd100, 8'd200);
        bus.resp0_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (acc_cyc.size() > 0) break;
        end
        set_req(0, 1'b0, 8'd0, 8'd0);
        acc = (acc_cyc.size() > 0) ? acc_cyc[0] : cyc;
        for (int i = 0; i < 10; i++) begin
            if (cyc >= acc + 6) break;
            @(negedge clk);
        end
        rst = 1'b1;
        set_req(0, 1'b1, 8'd9, 8'd9);
        set_req(1, 1'b1, 8'd9, 8'd9);
        #1;
        n_tests++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.resp0_valid !== 1'b0 ||
                       bus.resp1_valid !== 1'b0 || bus.mul_rst !== 1'b1) begin
            n_fail++; $display("FAIL midrst_outputs: got rdy=%b%b vld=%b%b mul_rst=%b want 00 00 1",
                               bus.req1_ready, bus.req0_ready, bus.resp1_valid, bus.resp0_valid, bus.mul_rst);
        end
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b0, 8'd0, 8'd0);
        set_req(1, 1'b0, 8'd0, 8'd0);
        #1;
        n_tests++; if (bus.mul_in1 !== 8'd0 || bus.mul_in2 !== 8'd0 || bus.resp_data !== 16'd0) begin
            n_fail++; $display("FAIL midrst_regs: got in=%0d,%0d data=%0d want 0,0,0", bus.mul_in1, bus.mul_in2, bus.resp_data);
        end
        repeat (20) @(negedge clk);
        n_tests++; if (rv0_q.size() != 0 || rv1_q.size() != 0) begin
            n_fail++; $display("FAIL midrst_dropped: got %0d/%0d valid cycles want 0/0", rv0_q.size(), rv1_q.size());
        end
        run_job(1, 8'd6, 8'd7, ok, d, lat);
        n_tests++; if (!ok || lat != 12 || d !== 16'd42) begin
            n_fail++; $display("FAIL midrst_new_job: got %0d lat=%0d ok=%0d want 42 lat=12", d, lat, ok);
        end
    endtask

    task automatic test_late_valid();
        logic [7:0] a1, b1, a0, b0;
        int bad = 0;
        int r1;
        a1 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
        a0 = 8'($urandom_range(0, 255)); b0 = 8'($urandom_range(0, 255));
        do_reset();
        set_req(1, 1'b1, a1, b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (acc_cyc.size() > 0) break;
        end
        set_req(1, 1'b0, 8'd0, 8'd0);
        repeat (4) @(negedge clk);
        set_req(0, 1'b1, a0, b0);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.req0_ready !== 1'b0) bad++;
            if (bus.resp1_valid) break;
            @(negedge clk);
        end
        n_tests++; if (bad != 0 || bus.resp1_valid !== 1'b1) begin
            n_fail++; $display("FAIL late_stall: got %0d ready cycles resp1_valid=%b want 0,1", bad, bus.resp1_valid);
        end
        bus.resp1_ready = 1'b1;
        @(negedge clk);
        bus.resp1_ready = 1'b0;
        #1;
        n_tests++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL late_first_idle: got req0_ready=%b want 1", bus.req0_ready); end
        bus.resp0_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (acc_cyc.size() > 1) set_req(0, 1'b0, 8'd0, 8'd0);
            if (hs_cyc.size() > 1) break;
        end
        bus.resp0_ready = 1'b0;
        n_tests++; if (hs_cyc.size() < 2 || acc_cyc.size() < 2) begin
            n_fail++; $display("FAIL late_timeout: got %0d responses want 2", hs_cyc.size());
        end else begin
            r1 = hs_cyc[0];
            n_tests++; if (hs_who[0] != 1 || hs_data[0] !== 16'(int'(a1) * int'(b1))) begin
                n_fail++; $display("FAIL late_req1_result: got resp%0d %0d want resp1 %0d", hs_who[0], hs_data[0], int'(a1) * int'(b1));
            end
            n_tests++; if (acc_who[1] != 0 || acc_cyc[1] != r1 + 1) begin
                n_fail++; $display("FAIL late_accept_cycle: got req%0d at %0d want req0 at %0d", acc_who[1], acc_cyc[1], r1 + 1);
            end
            n_tests++; if (hs_who[1] != 0 || hs_data[1] !== 16'(int'(a0) * int'(b0))) begin
                n_fail++; $display("FAIL late_req0_result: got resp%0d %0d want resp0 %0d", hs_who[1], hs_data[1], int'(a0) * int'(b0));
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_extremes();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_late_valid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
